// File: rtl/rgbw_pkg.sv
// Shared types and constants for the RGBW multiplier arbiter.
package rgbw_pkg;

  localparam int unsigned N_REQ_DEF        = 4;
  localparam int unsigned MULT_TIMEOUT_DEF = 20;
  localparam int unsigned OP_W             = 8;
  localparam int unsigned PROD_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } operands_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester and multiplier-side signals of the arbiter, bundled as one bus.
interface mult_arbiter_if #(
  parameter int unsigned N_REQ = rgbw_pkg::N_REQ_DEF
);
  import rgbw_pkg::*;

  logic [N_REQ-1:0]      req;
  logic [OP_W*N_REQ-1:0] req_a;
  logic [OP_W*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]      gnt;
  logic [N_REQ-1:0]      done;
  logic [PROD_W-1:0]     res;
  logic                  err;
  logic                  mult_ld;
  logic [OP_W-1:0]       mult_a;
  logic [OP_W-1:0]       mult_b;
  logic                  mult_rdy;
  logic [PROD_W-1:0]     mult_res;

  // Arbiter side
  modport slave (
    input  req, req_a, req_b, mult_rdy, mult_res,
    output gnt, done, res, err, mult_ld, mult_a, mult_b
  );

  // Requesters plus multiplier side
  modport master (
    output req, req_a, req_b, mult_rdy, mult_res,
    input  gnt, done, res, err, mult_ld, mult_a, mult_b
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin selector: first requester above ptr, wrapping around.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             valid
);

  int unsigned idx;

  // Scan ptr+1, ptr+2, ... ptr+N_REQ (mod N_REQ) and keep the first hit
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = (32'(ptr) + i) % N_REQ;
      if (!valid && req[PTR_W'(idx)]) begin
        gnt[PTR_W'(idx)] = 1'b1;
        valid            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one 8x8 multiplier among N_REQ requesters.
module mult_arbiter
  import rgbw_pkg::*;
#(
  parameter int unsigned N_REQ        = N_REQ_DEF,
  parameter int unsigned MULT_TIMEOUT = MULT_TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_half,
  mult_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = (MULT_TIMEOUT > 1) ? $clog2(MULT_TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  win_q;
  operands_t         ops_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PROD_W-1:0] res_q;
  logic              err_q;

  logic [N_REQ-1:0]  pick_gnt;
  logic              pick_valid;
  logic [PTR_W-1:0]  pick_idx;
  operands_t         pick_ops;
  logic [N_REQ-1:0]  win_oh;

  logic load_win, clr_cnt, inc_cnt, cap_rdy, cap_tmo, upd_ptr;
  logic mult_ld_c, done_en_c;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Convert the one-hot pick into an index and select its operands
  always_comb begin
    pick_idx = '0;
    pick_ops = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        pick_idx   = PTR_W'(i);
        pick_ops.a = bus.req_a[i*OP_W +: OP_W];
        pick_ops.b = bus.req_b[i*OP_W +: OP_W];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and datapath controls; nothing moves while clk_half is low
  always_comb begin
    state_d   = state_q;
    load_win  = 1'b0;
    clr_cnt   = 1'b0;
    inc_cnt   = 1'b0;
    cap_rdy   = 1'b0;
    cap_tmo   = 1'b0;
    upd_ptr   = 1'b0;
    mult_ld_c = 1'b0;
    done_en_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clk_half && pick_valid) begin
          load_win = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        mult_ld_c = clk_half;
        if (clk_half) begin
          clr_cnt = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (clk_half) begin
          // A ready result beats a timeout landing on the same cycle
          if (bus.mult_rdy) begin
            cap_rdy = 1'b1;
            state_d = ST_DONE;
          end else if (cnt_q == CNT_W'(MULT_TIMEOUT - 1)) begin
            cap_tmo = 1'b1;
            state_d = ST_DONE;
          end else begin
            inc_cnt = 1'b1;
          end
        end
      end
      ST_DONE: begin
        done_en_c = clk_half;
        if (clk_half) begin
          upd_ptr = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Winner, operands, wait counter, result and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q <= '0;
      ops_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      ptr_q <= PTR_W'(N_REQ - 1);
    end else begin
      if (load_win) begin
        win_q <= pick_idx;
        ops_q <= pick_ops;
      end
      if (clr_cnt) cnt_q <= '0;
      else if (inc_cnt && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
      if (cap_rdy) begin
        res_q <= bus.mult_res;
        err_q <= 1'b0;
      end else if (cap_tmo) begin
        res_q <= '0;
        err_q <= 1'b1;
      end
      if (upd_ptr) ptr_q <= win_q;
    end
  end

  assign win_oh = N_REQ'(1) << win_q;

  // Strobes follow clk_half so they last one clk; reset suppresses them at once
  assign bus.mult_ld = mult_ld_c & ~reset;
  assign bus.done    = (done_en_c && !reset) ? win_oh : '0;
  assign bus.gnt     = (state_q != ST_IDLE) ? win_oh : '0;
  assign bus.mult_a  = (state_q != ST_IDLE) ? ops_q.a : '0;
  assign bus.mult_b  = (state_q != ST_IDLE) ? ops_q.b : '0;
  assign bus.res     = res_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a transaction-level reference model.
module tb_mult_arbiter;
  import rgbw_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 20;
  localparam int unsigned PW  = $clog2(N);

  logic clk = 1'b0;
  logic reset;
  logic clk_half;

  mult_arbiter_if #(.N_REQ(N)) bus ();

  mult_arbiter #(
    .N_REQ        (N),
    .MULT_TIMEOUT (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_half (clk_half),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_ptr;
  logic [7:0] opa [N];
  logic [7:0] opb [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      opa[i] = 8'($urandom);
      opb[i] = 8'($urandom);
    end
  endtask

  task automatic pack_ops();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*8 +: 8] = opa[i];
      bus.req_b[i*8 +: 8] = opb[i];
    end
  endtask

  // Round-robin model: first requester strictly after the last winner
  function automatic int model_pick(input logic [N-1:0] rq, input int last);
    int w;
    logic [N-1:0] sh;
    w = -1;
    for (int i = 1; i <= N; i++) begin
      sh = rq >> ((last + i) % N);
      if (w < 0 && sh[0]) w = (last + i) % N;
    end
    return w;
  endfunction

  // One full transaction, cycle by cycle. k = WAIT cycle (1-based, enabled)
  // on which mult_rdy is returned; k outside 1..TMO means never -> timeout.
  task automatic run_txn(input logic [N-1:0] rq, input int k, input bit toggle,
                         input bit force7, input bit drop);
    int w, wcyc, e, cyc, cur;
    bit en;
    logic [N-1:0] oh;
    logic [15:0] prod, exp_res;
    logic exp_err;
    w = model_pick(rq, m_ptr);
    oh = N'(1) << w;
    prod = 16'(opa[PW'(w)]) * 16'(opb[PW'(w)]);
    if (k >= 1 && k <= int'(TMO)) begin
      wcyc = k;
      exp_err = 1'b0;
      exp_res = force7 ? 16'd7 : prod;
    end else begin
      wcyc = TMO;
      exp_err = 1'b1;
      exp_res = 16'h0000;
    end
    bus.req = rq;
    pack_ops();
    e = 0;
    cyc = 0;
    while (e < wcyc + 3) begin
      cur = e + 1;  // 1=IDLE, 2=LOAD, 3..wcyc+2=WAIT, wcyc+3=DONE
      en = toggle ? (cyc % 2 == 0) : 1'b1;
      clk_half = en;
      if (drop && cur >= 3) bus.req = rq & ~oh;
      bus.mult_rdy = 1'b0;
      bus.mult_res = 16'($urandom);
      if (en && cur == k + 2 && !exp_err) begin
        bus.mult_rdy = 1'b1;
        bus.mult_res = force7 ? 16'd7 : prod;
      end else if (en && (cur <= 2 || cur == wcyc + 3)) begin
        bus.mult_rdy = 1'($urandom);
      end
      #1;
      chk("gnt", 32'(bus.gnt), (cur == 1) ? 32'd0 : 32'(oh));
      chk("mult_ld", 32'(bus.mult_ld), 32'(en && cur == 2));
      chk("mult_a", 32'(bus.mult_a), (cur == 1) ? 32'd0 : 32'(opa[PW'(w)]));
      chk("mult_b", 32'(bus.mult_b), (cur == 1) ? 32'd0 : 32'(opb[PW'(w)]));
      chk("done", 32'(bus.done), (en && cur == wcyc + 3) ? 32'(oh) : 32'd0);
      if (en && cur == wcyc + 3) begin
        chk("res", 32'(bus.res), 32'(exp_res));
        chk("err", 32'(bus.err), 32'(exp_err));
      end
      step();
      if (en) e++;
      cyc++;
    end
    m_ptr = w;
    bus.mult_rdy = 1'b0;
  endtask

  initial begin
    logic [N-1:0] rq;
    reset = 1'b1;
    clk_half = 1'b1;
    bus.req = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.mult_rdy = 1'b0;
    bus.mult_res = '0;
    rand_ops();
    repeat (2) step();
    clk_half = 1'b0;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_mult_ld", 32'(bus.mult_ld), 32'd0);
    chk("rst_mult_a", 32'(bus.mult_a), 32'd0);
    chk("rst_res", 32'(bus.res), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    step();
    reset = 1'b0;
    m_ptr = N - 1;

    // Single request 12*10 with ready 3 cycles after load
    opa[0] = 8'd12;
    opb[0] = 8'd10;
    run_txn(4'b0001, 3, 1'b0, 1'b0, 1'b0);

    // Fairness with all four requesting
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      run_txn(4'b1111, $urandom_range(1, 6), 1'b0, 1'b0, 1'b0);
    end

    // Timeout, then a normal transaction from the same requester
    rand_ops();
    run_txn(4'b0100, 0, 1'b0, 1'b0, 1'b0);
    run_txn(4'b0100, 5, 1'b0, 1'b0, 1'b0);

    // clk_half toggling, full-scale operands
    opa[1] = 8'd255;
    opb[1] = 8'd255;
    run_txn(4'b0010, 2, 1'b1, 1'b0, 1'b0);

    // Ready on the timeout cycle wins
    rand_ops();
    run_txn(4'b0001, TMO, 1'b0, 1'b1, 1'b0);

    // Winner drops its request mid-transaction
    rand_ops();
    run_txn(4'b0110, 4, 1'b0, 1'b0, 1'b1);

    // Randomized transactions
    for (int r = 0; r < 24; r++) begin
      rand_ops();
      rq = N'($urandom_range(1, (1 << N) - 1));
      run_txn(rq, $urandom_range(0, 24), 1'($urandom), 1'b0, 1'($urandom));
    end

    // Reset while waiting on the multiplier
    rand_ops();
    pack_ops();
    clk_half = 1'b1;
    bus.req = 4'b1000;
    repeat (3) step();
    chk("pre_rst_gnt", 32'(bus.gnt), 32'h8);
    reset = 1'b1;
    #1;
    chk("in_rst_done", 32'(bus.done), 32'd0);
    step();
    reset = 1'b0;
    bus.req = '0;
    #1;
    chk("post_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("post_rst_mult_ld", 32'(bus.mult_ld), 32'd0);
    chk("post_rst_mult_a", 32'(bus.mult_a), 32'd0);
    chk("post_rst_mult_b", 32'(bus.mult_b), 32'd0);
    chk("post_rst_done", 32'(bus.done), 32'd0);
    chk("post_rst_res", 32'(bus.res), 32'd0);
    chk("post_rst_err", 32'(bus.err), 32'd0);
    bus.mult_rdy = 1'b1;
    bus.mult_res = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.mult_rdy = 1'b0;
      #1;
      chk("late_rdy_done", 32'(bus.done), 32'd0);
      chk("late_rdy_gnt", 32'(bus.gnt), 32'd0);
      chk("late_rdy_res", 32'(bus.res), 32'd0);
    end
    m_ptr = N - 1;
    run_txn(4'b1001, 2, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- N_REQ, 4, number of requesters (R, G, B, W channels)
- MULT_TIMEOUT, 20, maximum enabled WAIT cycles before abort
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- clk  in  1  single system clock; all state on rising edge
- reset  in  1  synchronous, active-high
- clk_half  in  1  clock enable; FSM, pointer and counter advance only on clk edges with clk_half=1
- req  in  N_REQ  per-requester request level; held until that requester's done
- req_a  in  8*N_REQ  operand A, requester i at bits [8i+7:8i]
- req_b  in  8*N_REQ  operand B, same packing
- gnt  out  N_REQ  one-hot grant
- done  out  N_REQ  one-hot completion pulse
- res  out  16  product, valid while any done bit is high
- err  out  1  timeout flag, valid while any done bit is high
- mult_ld  out  1  load strobe to the shared 8x8 multiplier
- mult_a  out  8  operand A to the multiplier
- mult_b  out  8  operand B to the multiplier
- mult_rdy  in  1  multiplier result-ready
- mult_res  in  16  multiplier product

Function
REQ-003 FSM states SHALL be IDLE, LOAD, WAIT, DONE; all transitions SHALL require clk_half=1.
REQ-004 IDLE: if req is nonzero, the block SHALL pick a winner by round-robin, starting at index ptr+1 mod N_REQ and searching upward; it SHALL latch the winner's req_a/req_b and index, set gnt one-hot, and go to LOAD.
REQ-005 IDLE with req all zero SHALL stay in IDLE with gnt=0.
REQ-006 LOAD: mult_ld SHALL equal clk_half, so exactly one clk cycle is high; the wait counter SHALL clear; the next state SHALL be WAIT.
REQ-007 mult_a/mult_b SHALL drive the latched operands from LOAD through DONE; they SHALL be 0 in IDLE.
REQ-008 WAIT, mult_rdy=1: res SHALL capture mult_res, err SHALL be set to 0, and the next state SHALL be DONE.
REQ-009 WAIT, mult_rdy=0: the counter SHALL increment; when the counter equals MULT_TIMEOUT-1, res SHALL be set to 16'h0000, err to 1, and the next state SHALL be DONE.
REQ-010 If mult_rdy=1 and the timeout are reached in the same cycle, mult_rdy SHALL win (err=0).
REQ-011 DONE: done[winner] SHALL equal clk_half (exactly one clk cycle high); ptr SHALL be set to the winner; the next state SHALL be IDLE.
REQ-012 gnt SHALL stay high from LOAD through DONE and SHALL be 0 in IDLE.
REQ-013 If the winner drops req mid-transaction, the transaction SHALL still complete and done SHALL still pulse.
REQ-014 Minimum spacing SHALL be 4 enabled cycles per transaction; with clk_half=1 continuously and mult_rdy k cycles after mult_ld, done SHALL occur k+2 cycles after the IDLE grant edge.
REQ-015 mult_rdy/mult_res outside WAIT SHALL be ignored.
REQ-016 The counter SHALL be $clog2(MULT_TIMEOUT) bits wide and SHALL saturate rather than wrap.

Reset
REQ-017 Reset SHALL force: state=IDLE, gnt=0, done=0, mult_ld=0, mult_a=0, mult_b=0, res=0, err=0, counter=0, ptr=N_REQ-1 (requester 0 first), independent of clk_half.
REQ-018 Reset during LOAD/WAIT/DONE SHALL abort the transaction with no done pulse; a later mult_rdy SHALL be ignored.

Structure
REQ-019 A shared package rgbw_pkg SHALL hold the FSM state enum, the N_REQ and MULT_TIMEOUT defaults, and the operand/product width constants (8, 16).
REQ-020 The round-robin selector SHALL be a separate combinational sub-module rr_pick, with inputs req and ptr and outputs a one-hot grant and a valid bit.
REQ-021 Budget: 150-300 RTL lines; no latches; single clock domain.

Verification
REQ-022 Single request: req=0001, a=8'd12, b=8'd10, mult_rdy 3 cycles after mult_ld, mult_res=16'd120 -> done=0001, res=120, err=0, one mult_ld pulse.
REQ-023 Fairness: req=1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3; never two grants in one transaction.
REQ-024 Timeout: req=0100, mult_rdy never asserted -> done=0100 exactly 20 enabled WAIT cycles after LOAD, res=0, err=1; the next request is served normally.
REQ-025 clk_half toggling 1,0,1,0 with req=0010, a=b=8'd255, mult_res=16'd65025 -> mult_ld and done each high for exactly one clk cycle, res=65025, state held while clk_half=0.
REQ-026 Reset asserted in WAIT with req=1000 -> outputs zero the next cycle; a mult_rdy pulse afterwards produces no done; the first post-reset grant with req=1001 goes to requester 0.
REQ-027 Boundary: mult_rdy coinciding with the timeout cycle, mult_res=16'd7 -> err=0, res=7.
